// File: rtl/obs_sprite_if.sv
// Obstacle sprite engine bus: frame control and respawn in, pixel stream and position out.
// The master drives the frame control; the slave is the sprite engine.
interface obs_sprite_if;
  logic       frame_tick;
  logic       enable;
  logic [1:0] mode;
  logic       respawn;
  logic [7:0] spawn_x;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       busy;
  logic       done;
  logic [7:0] pos_x;
  logic [6:0] pos_y;

  modport master (
    output frame_tick, enable, mode, respawn, spawn_x,
    input  plot, x, y, colour, busy, done, pos_x, pos_y
  );

  modport slave (
    input  frame_tick, enable, mode, respawn, spawn_x,
    output plot, x, y, colour, busy, done, pos_x, pos_y
  );
endinterface

// File: rtl/obs_sprite_engine.sv
// Obstacle sprite engine: per frame tick, erase the old rectangle, step or respawn, then redraw,
// streaming one registered pixel per cycle toward the VGA adapter.
module obs_sprite_engine #(
  parameter int         OBJ_W     = 2,
  parameter int         OBJ_H     = 16,
  parameter int         X_MIN     = 0,
  parameter int         X_MAX     = 158,
  parameter int         Y_MIN     = 0,
  parameter int         Y_MAX     = 104,
  parameter int         STEP      = 1,
  parameter logic [2:0] FG_COLOUR = 3'b001,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input logic        clock,
  input logic        resetn,
  obs_sprite_if.slave bus
);
  localparam logic [3:0]        CX_LAST = 4'(OBJ_W - 1);
  localparam logic [3:0]        CY_LAST = 4'(OBJ_H - 1);
  localparam logic signed [9:0] XLO     = 10'(X_MIN);
  localparam logic signed [9:0] XHI     = 10'(X_MAX);
  localparam logic signed [9:0] YLO     = 10'(Y_MIN);
  localparam logic signed [9:0] YHI     = 10'(Y_MAX);
  localparam logic signed [9:0] STEP_S  = 10'(STEP);

  typedef enum logic [2:0] {IDLE, ERASE, MOVE, DRAW, DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cx, cy, cx_nxt, cy_nxt;
  logic [7:0]        pos_x, pos_x_nxt, x_q, x_nxt;
  logic [6:0]        pos_y, pos_y_nxt, y_q, y_nxt;
  logic              dir_x, dir_x_nxt, dir_y, dir_y_nxt;
  logic              drawn, drawn_nxt, pend, pend_nxt;
  logic              plot_q, plot_nxt, done_q, done_nxt, busy_q;
  logic [2:0]        colour_q, colour_nxt;
  logic              last_px, tick_ok, start, x_act, y_act;
  logic signed [9:0] px_s, py_s;

  // Bounce step on one axis; dir 1 means increasing coordinate (right/down).
  function automatic void step_axis(input logic signed [9:0] p, input logic d,
                                    input logic signed [9:0] lo, input logic signed [9:0] hi,
                                    output logic signed [9:0] p_o, output logic d_o);
    logic signed [9:0] n;
    if (d) begin
      n = p + STEP_S;
      if (n >= hi) begin p_o = hi; d_o = 1'b0; end
      else         begin p_o = n;  d_o = 1'b1; end
    end else begin
      n = p - STEP_S;
      if (n < lo)  begin p_o = lo; d_o = 1'b1; end
      else         begin p_o = n;  d_o = 1'b0; end
    end
  endfunction

  function automatic logic [7:0] clamp_x(input logic [7:0] v);
    logic signed [9:0] s;
    s = signed'({2'b00, v});
    if (s < XLO)      return 8'(XLO);
    else if (s > XHI) return 8'(XHI);
    else              return v;
  endfunction

  assign last_px = (cx == CX_LAST) && (cy == CY_LAST);
  assign tick_ok = bus.frame_tick & bus.enable;
  assign y_act   = ~bus.mode[0];
  assign x_act   = bus.mode[0] ^ bus.mode[1];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick_ok) state_nxt = drawn ? ERASE : DRAW;
      ERASE:   if (last_px) state_nxt = MOVE;
      MOVE:    state_nxt = DRAW;
      DRAW:    if (last_px) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cx_nxt     = cx;
    cy_nxt     = cy;
    pos_x_nxt  = pos_x;
    pos_y_nxt  = pos_y;
    dir_x_nxt  = dir_x;
    dir_y_nxt  = dir_y;
    drawn_nxt  = drawn;
    pend_nxt   = pend | bus.respawn;
    plot_nxt   = 1'b0;
    done_nxt   = 1'b0;
    x_nxt      = x_q;
    y_nxt      = y_q;
    colour_nxt = colour_q;
    start      = 1'b0;
    px_s       = '0;
    py_s       = '0;
    case (state)
      IDLE: begin
        // Nothing on screen yet, so a respawn can relocate without an erase pass.
        if (bus.respawn && !drawn) begin
          pos_x_nxt = clamp_x(bus.spawn_x);
          pos_y_nxt = 7'(YLO);
          dir_x_nxt = 1'b1;
          dir_y_nxt = 1'b1;
          pend_nxt  = 1'b0;
        end
        if (tick_ok) begin
          start      = 1'b1;
          colour_nxt = drawn ? BG_COLOUR : FG_COLOUR;
        end
      end
      ERASE, DRAW: begin
        if (!last_px) begin
          plot_nxt = 1'b1;
          if (cx == CX_LAST) begin
            cx_nxt = '0;
            cy_nxt = cy + 4'd1;
          end else begin
            cx_nxt = cx + 4'd1;
          end
        end
      end
      MOVE: begin
        if (pend) begin
          pos_x_nxt = clamp_x(bus.spawn_x);
          pos_y_nxt = 7'(YLO);
          dir_x_nxt = 1'b1;
          dir_y_nxt = 1'b1;
          pend_nxt  = bus.respawn;
        end else begin
          if (y_act) begin
            step_axis(signed'({3'b000, pos_y}), dir_y, YLO, YHI, py_s, dir_y_nxt);
            pos_y_nxt = 7'(py_s);
          end
          if (x_act) begin
            step_axis(signed'({2'b00, pos_x}), dir_x, XLO, XHI, px_s, dir_x_nxt);
            pos_x_nxt = 8'(px_s);
          end
        end
        start      = 1'b1;
        colour_nxt = FG_COLOUR;
      end
      DONE:    drawn_nxt = 1'b1;
      default: ;
    endcase
    if (state == DRAW && last_px) done_nxt = 1'b1;
    if (start) begin
      cx_nxt   = '0;
      cy_nxt   = '0;
      plot_nxt = 1'b1;
    end
    if (plot_nxt) begin
      x_nxt = pos_x_nxt + {4'b0000, cx_nxt};
      y_nxt = pos_y_nxt + {3'b000, cy_nxt};
    end
  end

  // Registered outputs and datapath state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cx       <= '0;
      cy       <= '0;
      pos_x    <= 8'(XLO);
      pos_y    <= 7'(YLO);
      dir_x    <= 1'b1;
      dir_y    <= 1'b1;
      drawn    <= 1'b0;
      pend     <= 1'b0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= BG_COLOUR;
    end else begin
      cx       <= cx_nxt;
      cy       <= cy_nxt;
      pos_x    <= pos_x_nxt;
      pos_y    <= pos_y_nxt;
      dir_x    <= dir_x_nxt;
      dir_y    <= dir_y_nxt;
      drawn    <= drawn_nxt;
      pend     <= pend_nxt;
      plot_q   <= plot_nxt;
      done_q   <= done_nxt;
      busy_q   <= (state_nxt != IDLE);
      x_q      <= x_nxt;
      y_q      <= y_nxt;
      colour_q <= colour_nxt;
    end
  end

  assign bus.plot   = plot_q;
  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.pos_x  = pos_x;
  assign bus.pos_y  = pos_y;
endmodule

// File: tb/tb_obs_sprite_engine.sv
// Randomized frame-level bench for obs_sprite_engine against a rectangle/bounce reference model.
module tb_obs_sprite_engine;
  localparam int         W   = 3;
  localparam int         H   = 4;
  localparam int         XMN = 5;
  localparam int         XMX = 40;
  localparam int         YMN = 3;
  localparam int         YMX = 30;
  localparam int         STP = 4;
  localparam logic [2:0] FG  = 3'b101;
  localparam logic [2:0] BG  = 3'b010;
  localparam int         N   = W * H;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  obs_sprite_if bus();

  obs_sprite_engine #(
    .OBJ_W(W), .OBJ_H(H), .X_MIN(XMN), .X_MAX(XMX), .Y_MIN(YMN), .Y_MAX(YMX),
    .STEP(STP), .FG_COLOUR(FG), .BG_COLOUR(BG)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;
  int m_px, m_py;
  bit m_dx, m_dy, m_drawn, m_pend;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  function automatic int clampx(input int v);
    return (v < XMN) ? XMN : ((v > XMX) ? XMX : v);
  endfunction

  function automatic int pix(input int px, input int py, input int c);
    return (px << 10) | (py << 3) | c;
  endfunction

  function automatic int pos_of(input int px, input int py);
    return (px << 7) | py;
  endfunction

  task automatic mstep(inout int p, inout bit d, input int lo, input int hi);
    if (d) begin
      if (p + STP >= hi) begin p = hi; d = 1'b0; end
      else p = p + STP;
    end else begin
      if (p < lo + STP) begin p = lo; d = 1'b1; end
      else p = p - STP;
    end
  endtask

  task automatic model_reset();
    m_px = XMN; m_py = YMN; m_dx = 1'b1; m_dy = 1'b1; m_drawn = 1'b0; m_pend = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctl"}, {bus.plot, bus.busy, bus.done}, 3'b000);
    check_eq({tag, "_xy"}, {bus.x, bus.y}, 15'd0);
    check_eq({tag, "_colour"}, bus.colour, BG);
    check_eq({tag, "_pos"}, {bus.pos_x, bus.pos_y}, pos_of(XMN, YMN));
  endtask

  task automatic idle_respawn(input logic [7:0] sx);
    bus.spawn_x = sx;
    bus.respawn = 1'b1;
    next_cycle();
    bus.respawn = 1'b0;
    if (m_drawn) m_pend = 1'b1;
    else begin
      m_px = clampx(sx); m_py = YMN; m_dx = 1'b1; m_dy = 1'b1; m_pend = 1'b0;
    end
    check_eq("idle_respawn_pos", {bus.pos_x, bus.pos_y}, pos_of(m_px, m_py));
    check_eq("idle_respawn_ctl", {bus.plot, bus.busy, bus.done}, 3'b000);
  endtask

  // Tick issued in the current cycle (cycle 0); checks every cycle through the first idle cycle.
  task automatic run_frame(input logic [1:0] md, input logic [7:0] sx, input int rk,
                           input bit busy_tick, input bit done_tick);
    int q[$];
    int dc, ox, oy, nx, ny;
    bit was_drawn, pend_move, pl;
    logic [2:0] e;
    bus.mode    = md;
    bus.spawn_x = sx;
    was_drawn   = m_drawn;
    ox = m_px; oy = m_py;
    dc = was_drawn ? 2 * N + 2 : N + 1;
    if (was_drawn) begin
      for (int j = 0; j < H; j++)
        for (int i = 0; i < W; i++) q.push_back(pix(ox + i, oy + j, BG));
      pend_move = m_pend || (rk >= 1 && rk <= N);
      if (pend_move) begin
        m_px = clampx(sx); m_py = YMN; m_dx = 1'b1; m_dy = 1'b1; m_pend = 1'b0;
      end else begin
        if (md == 2'b00 || md == 2'b10) mstep(m_py, m_dy, YMN, YMX);
        if (md == 2'b01 || md == 2'b10) mstep(m_px, m_dx, XMN, XMX);
      end
      if (rk >= N + 1) m_pend = 1'b1;
    end else if (rk >= 1) m_pend = 1'b1;
    nx = m_px; ny = m_py;
    for (int j = 0; j < H; j++)
      for (int i = 0; i < W; i++) q.push_back(pix(nx + i, ny + j, FG));
    m_drawn = 1'b1;

    bus.frame_tick = 1'b1;
    bus.enable     = 1'b1;
    for (int c = 1; c <= dc + 1; c++) begin
      next_cycle();
      bus.frame_tick = (busy_tick && c == 3) || (done_tick && c == dc);
      bus.respawn    = (c == rk);
      pl = (c >= 1 && c <= N) || (was_drawn && c >= N + 2 && c <= 2 * N + 1);
      e  = {pl, (c <= dc), (c == dc)};
      check_eq("ctl", {bus.plot, bus.busy, bus.done}, e);
      if (pl && q.size() > 0)
        check_eq("pixel", pix(int'(bus.x), int'(bus.y), int'(bus.colour)), q.pop_front());
      check_eq("pos", {bus.pos_x, bus.pos_y},
               (was_drawn && c <= N + 1) ? pos_of(ox, oy) : pos_of(nx, ny));
    end
    bus.respawn = 1'b0;
    check_eq("pixels_left", q.size(), 0);
  endtask

  task automatic random_frame();
    int dcx, rk;
    dcx = m_drawn ? 2 * N + 2 : N + 1;
    rk  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, dcx)) : 0;
    run_frame(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), rk,
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    repeat ($urandom_range(0, 2)) begin
      if (m_drawn && $urandom_range(0, 5) == 0) idle_respawn(8'($urandom_range(0, 255)));
      else begin
        next_cycle();
        check_eq("idle_ctl", {bus.plot, bus.busy, bus.done}, 3'b000);
      end
    end
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.enable     = 1'b1;
    bus.mode       = 2'b00;
    bus.respawn    = 1'b0;
    bus.spawn_x    = 8'd0;
    model_reset();
    repeat (3) next_cycle();
    check_reset_outputs("reset");
    resetn = 1'b1;
    next_cycle();

    // Immediate relocation while nothing is drawn, clamped on both sides.
    idle_respawn(8'd2);
    idle_respawn(8'd250);

    // Tick with enable low is ignored.
    bus.enable     = 1'b0;
    bus.frame_tick = 1'b1;
    next_cycle();
    bus.frame_tick = 1'b0;
    bus.enable     = 1'b1;
    repeat (3) begin
      next_cycle();
      check_eq("enable_off_ctl", {bus.plot, bus.busy, bus.done}, 3'b000);
    end

    for (int f = 0; f < 80; f++) random_frame();

    // Asynchronous reset in the middle of an erase scan.
    bus.mode       = 2'b10;
    bus.frame_tick = 1'b1;
    next_cycle();
    bus.frame_tick = 1'b0;
    for (int c = 2; c <= 10; c++) next_cycle();
    check_eq("erase_mid_plot", bus.plot, 1'b1);
    #2 resetn = 1'b0;
    #1 check_reset_outputs("async_reset");
    next_cycle();
    check_reset_outputs("async_reset_hold");
    resetn = 1'b1;
    model_reset();
    next_cycle();
    run_frame(2'b10, 8'd0, 0, 1'b0, 1'b0);

    for (int f = 0; f < 30; f++) random_frame();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/obs_sprite_engine.md
# obs_sprite_engine

Parametrised obstacle sprite engine for the VGA obstacle-dodger datapath. Once per frame tick it erases the obstacle rectangle at its old position, advances the position by a configurable step with bounce at programmable bounds (vertical, horizontal or diagonal mode), then redraws it. It emits one pixel per cycle with a `plot` strobe toward the VGA adapter, and exposes the current position to the collision logic. Respawn at an externally supplied x position (e.g. from the LFSR) is supported.

## Interface
- OBJ_W, 2: obstacle width in pixels (1..16)
- OBJ_H, 16: obstacle height in pixels (1..16)
- X_MIN, 0: leftmost legal top-left x
- X_MAX, 158: rightmost legal top-left x (must be ≤ 160-OBJ_W)
- Y_MIN, 0: topmost legal top-left y
- Y_MAX, 104: bottommost legal top-left y (must be ≤ 120-OBJ_H)
- STEP, 1: pixels moved per frame per active axis (1..15)
- FG_COLOUR, 3'b001: obstacle colour
- BG_COLOUR, 3'b000: erase colour

Ports:
- clock  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- frame_tick  in  1  one-cycle pulse per animation frame
- enable  in  1  frame_tick is accepted only when 1
- mode  in  2  00 vertical bounce, 01 horizontal bounce, 10 diagonal, 11 frozen (redraw in place)
- respawn  in  1  one-cycle pulse requesting a relocation
- spawn_x  in  8  x position used on respawn
- plot  out  1  pixel strobe, x/y/colour valid when 1
- x  out  8  pixel x
- y  out  7  pixel y
- colour  out  3  pixel colour
- busy  out  1  1 while not IDLE
- done  out  1  one-cycle pulse at end of each frame update
- pos_x  out  8  current top-left x
- pos_y  out  7  current top-left y

## Operation
- States: IDLE, ERASE, MOVE, DRAW, DONE.
- IDLE: on `frame_tick & enable` go to ERASE if `drawn`=1, else DRAW. Ticks received while busy are dropped, not queued.
- ERASE/DRAW: scan counters cx (0..OBJ_W-1, fastest) and cy (0..OBJ_H-1). Each cycle output plot=1, x=pos_x+cx, y=pos_y+cy, colour=BG_COLOUR (ERASE) or FG_COLOUR (DRAW). After the last pixel, ERASE→MOVE and DRAW→DONE.
- MOVE (one cycle, plot=0):
  - If `respawn_pend` is set: pos_x=clamp(spawn_x, X_MIN, X_MAX), pos_y=Y_MIN, dir_x=right, dir_y=down, and clear the pending flag.
  - Otherwise step each active axis. y is active in modes 00 and 10; x is active in modes 01 and 10.
  - Down: n=pos_y+STEP, computed in 9 bits. If n≥Y_MAX then pos_y=Y_MAX and dir_y=up, else pos_y=n.
  - Up: if pos_y<Y_MIN+STEP then pos_y=Y_MIN and dir_y=down, else pos_y=pos_y-STEP.
  - x axis behaves identically against X_MIN/X_MAX.
  - Then go to DRAW.
- DONE: done=1 for one cycle, drawn=1, return to IDLE.
- respawn pulse in any state sets `respawn_pend`. If it arrives in IDLE with drawn=0, position loads immediately (no erase needed).
- Reset values: state IDLE, pos_x=X_MIN, pos_y=Y_MIN, dir right/down, drawn=0, respawn_pend=0, plot=0, x=0, y=0, colour=BG_COLOUR, busy=0, done=0.
- Reset mid-frame: scan is abandoned immediately. The partial image is left on screen (accepted).

## Timing
- All outputs are registered. N = OBJ_W·OBJ_H.
- frame_tick at cycle 0 with drawn=1:
  - plot high cycles 1..N (erase)
  - MOVE at cycle N+1
  - plot high cycles N+2..2N+1 (draw)
  - done at cycle 2N+2
  - busy high cycles 1..2N+2
- drawn=0: plot high cycles 1..N (draw), done at N+1.
- plot is never high outside ERASE/DRAW. x/y hold their last value while plot=0.
- pos_x/pos_y change only in MOVE (or on IDLE respawn). They are stable during each scan.
- A tick arriving in the same cycle as done is dropped. A tick one cycle later is accepted.

## Test plan
- Defaults. Reset, then tick: 32 plot cycles at (0..1, 0..15) colour 001, done at cycle 33. Second tick: 32 erase pixels colour 000 at y 0..15, then 32 draw pixels at y 1..16, done at cycle 66.
- Bounce. Force pos_y=103 with STEP=1, dir down: one tick gives pos_y=104 and dir up; next tick gives pos_y=103. With STEP=4 from pos_y=2 going up: pos_y=0 and dir down.
- Diagonal. mode=10, X_MIN=0, X_MAX=158: from (0,0), three ticks give (3,3). At x=158 dir_x flips and the next tick gives x=157.
- Respawn. Pulse respawn (spawn_x=200) during DRAW. The next tick erases the old image, then draws at (158,0); no movement step is applied that frame.
- Ignored tick and enable. A tick while busy=1 produces no extra frame. A tick with enable=0 leaves busy=0 and plot=0.
- Async reset at erase pixel 10: outputs return to reset values without a clock edge. The next tick draws at (0,0) with no erase.
